// File: rtl/dynamic_multi_bit_sreg_v2_pkg.sv
// Shared sizing helpers for the programmable-delay shift register.
package sreg_pkg;

    // Width of the depth select; never narrower than one bit.
    function automatic int sreg_dw(input int max_depth);
        int w;
        w = $clog2(max_depth);
        return (w < 1) ? 1 : w;
    endfunction

    // Width of the fill counter, which must be able to hold max_depth itself.
    function automatic int sreg_fw(input int max_depth);
        return $clog2(max_depth + 1);
    endfunction

endpackage

// File: rtl/dynamic_multi_bit_sreg_v2_if.sv
// Data/control bundle between a stream source and the delay line.
interface dynamic_multi_bit_sreg_v2_if
    import sreg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_DEPTH = 16
);
    localparam int DW = sreg_dw(MAX_DEPTH);

    logic             ce;
    logic             flush;
    logic [DW-1:0]    depth_sel;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] so;
    logic             so_valid;

    modport master (
        output ce, flush, depth_sel, si,
        input  so, so_valid
    );

    modport slave (
        input  ce, flush, depth_sel, si,
        output so, so_valid
    );
endinterface

// File: rtl/dynamic_multi_bit_sreg_v2_bit.sv
// One bit lane of the delay line: unreset storage plus its tap mux.
// Storage is deliberately left without reset so it maps onto SRL primitives.
module dynamic_single_bit_sreg_v2
    import sreg_pkg::*;
#(
    parameter int    MAX_DEPTH     = 16,
    parameter string SRL_STYLE_VAL = "srl"
) (
    input  logic                          clk,
    input  logic                          ce,
    input  logic                          si,
    input  logic [sreg_dw(MAX_DEPTH)-1:0] addr,
    output logic                          q
);
    (* srl_style = SRL_STYLE_VAL *) logic [MAX_DEPTH-1:0] sr;

    // Shift toward higher stages on each enabled edge.
    always_ff @(posedge clk) begin
        if (ce) begin
            sr <= {sr[MAX_DEPTH-2:0], si};
        end
    end

    // addr arrives already clamped to MAX_DEPTH-1 by the parent.
    assign q = sr[addr];
endmodule

// File: rtl/dynamic_multi_bit_sreg_v2.sv
// Multi-bit programmable delay line with fill tracking, flush and optional
// output register. Delay is depth_sel+1 enabled cycles (+1 clk when OREG=1).
module dynamic_multi_bit_sreg_v2
    import sreg_pkg::*;
#(
    parameter int    WIDTH         = 4,
    parameter int    MAX_DEPTH     = 16,
    parameter string SRL_STYLE_VAL = "srl",
    parameter int    OREG          = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dynamic_multi_bit_sreg_v2_if.slave bus
);
    localparam int DW = sreg_dw(MAX_DEPTH);
    localparam int FW = sreg_fw(MAX_DEPTH);
    localparam logic [FW-1:0] FILL_MAX = FW'(MAX_DEPTH);
    localparam logic [DW-1:0] LAST_SEL = DW'(MAX_DEPTH - 1);

    logic [DW-1:0]    eff_sel;
    logic [FW-1:0]    fill;
    logic [WIDTH-1:0] tap;
    logic             tap_valid;

    // Selects past the last stage (non-power-of-2 depths) fall back to it.
    always_comb begin
        eff_sel = bus.depth_sel;
        if (int'(bus.depth_sel) >= MAX_DEPTH) begin
            eff_sel = LAST_SEL;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dynamic_single_bit_sreg_v2 #(
            .MAX_DEPTH     (MAX_DEPTH),
            .SRL_STYLE_VAL (SRL_STYLE_VAL)
        ) u_lane (
            .clk  (clk),
            .ce   (bus.ce),
            .si   (bus.si[i]),
            .addr (eff_sel),
            .q    (tap[i])
        );
    end

    // Count words written since reset/flush; a word shifted during flush counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (bus.flush) begin
            fill <= bus.ce ? FW'(1) : '0;
        end else if (bus.ce && (fill < FILL_MAX)) begin
            fill <= fill + 1'b1;
        end
    end

    // Valid follows depth_sel live: storage is never cleared, so no refill needed.
    assign tap_valid = (fill > FW'(eff_sel));

    if (OREG != 0) begin : g_oreg
        logic [WIDTH-1:0] so_q;
        logic             so_valid_q;

        // Output stage runs every clk so depth changes land on the next edge.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                so_q       <= '0;
                so_valid_q <= 1'b0;
            end else begin
                so_q       <= tap;
                so_valid_q <= tap_valid;
            end
        end

        assign bus.so       = so_q;
        assign bus.so_valid = so_valid_q;
    end else begin : g_comb
        assign bus.so       = tap;
        assign bus.so_valid = tap_valid;
    end
endmodule

// File: tb/tb_dynamic_multi_bit_sreg_v2.sv
// Directed bench: three instances share one stimulus stream.
//   a: MAX_DEPTH=16, OREG=1   b: MAX_DEPTH=16, OREG=0   c: MAX_DEPTH=12, OREG=1
module tb_dynamic_multi_bit_sreg_v2;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic       flush;
    logic [3:0] depth_sel;
    logic [7:0] si;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dynamic_multi_bit_sreg_v2_if #(.WIDTH(8), .MAX_DEPTH(16)) if_a ();
    dynamic_multi_bit_sreg_v2_if #(.WIDTH(8), .MAX_DEPTH(16)) if_b ();
    dynamic_multi_bit_sreg_v2_if #(.WIDTH(8), .MAX_DEPTH(12)) if_c ();

    assign if_a.ce = ce;  assign if_a.flush = flush;  assign if_a.depth_sel = depth_sel;  assign if_a.si = si;
    assign if_b.ce = ce;  assign if_b.flush = flush;  assign if_b.depth_sel = depth_sel;  assign if_b.si = si;
    assign if_c.ce = ce;  assign if_c.flush = flush;  assign if_c.depth_sel = depth_sel;  assign if_c.si = si;

    dynamic_multi_bit_sreg_v2 #(.WIDTH(8), .MAX_DEPTH(16), .OREG(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    dynamic_multi_bit_sreg_v2 #(.WIDTH(8), .MAX_DEPTH(16), .OREG(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
    dynamic_multi_bit_sreg_v2 #(.WIDTH(8), .MAX_DEPTH(12), .OREG(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; flush = 1'b0; depth_sel = 4'd3; si = 8'd0;
        step(); step();
        chk("rst_a_so",    32'(if_a.so), 32'd0);
        chk("rst_a_valid", 32'(if_a.so_valid), 32'd0);
        chk("rst_b_valid", 32'(if_b.so_valid), 32'd0);
        chk("rst_c_valid", 32'(if_c.so_valid), 32'd0);
        rst_n = 1'b1;

        // continuous stream 1..8, depth 3
        for (int k = 1; k <= 8; k++) begin
            ce = 1'b1; si = 8'(k);
            step();
            chk("fill_a_valid", 32'(if_a.so_valid), 32'(k >= 5));
            chk("fill_b_valid", 32'(if_b.so_valid), 32'(k >= 4));
            if (k >= 5) chk("fill_a_so", 32'(if_a.so), 32'(k - 4));
            if (k >= 4) chk("fill_b_so", 32'(if_b.so), 32'(k - 3));
        end

        // ce toggling 1,0: storage holds across disabled edges
        for (int n = 9; n <= 12; n++) begin
            ce = 1'b1; si = 8'(n);
            step();
            chk("ce_on_a_so", 32'(if_a.so), 32'(n - 4));
            chk("ce_on_b_so", 32'(if_b.so), 32'(n - 3));
            ce = 1'b0; si = 8'hEE;
            step();
            chk("ce_off_a_so", 32'(if_a.so), 32'(n - 3));
            chk("ce_off_b_so", 32'(if_b.so), 32'(n - 3));
        end

        // fill past MAX_DEPTH (saturation)
        for (int n = 13; n <= 24; n++) begin
            ce = 1'b1; si = 8'(n);
            step();
            chk("sat_a_so", 32'(if_a.so), 32'(n - 4));
            chk("sat_b_so", 32'(if_b.so), 32'(n - 3));
        end
        chk("sat_a_valid", 32'(if_a.so_valid), 32'd1);

        // deepest tap: storage holds 24-k at stage k
        ce = 1'b0; depth_sel = 4'd15;
        #1;
        chk("deep_b_so_same_cycle", 32'(if_b.so), 32'd9);
        chk("deep_b_valid", 32'(if_b.so_valid), 32'd1);
        step();
        chk("deep_a_so",    32'(if_a.so), 32'd9);
        chk("deep_a_valid", 32'(if_a.so_valid), 32'd1);
        chk("clamp_c_so",   32'(if_c.so), 32'd13);
        chk("clamp_c_valid", 32'(if_c.so_valid), 32'd1);
        depth_sel = 4'd3;
        #1;
        chk("back_b_so", 32'(if_b.so), 32'd21);
        step();
        chk("back_a_so", 32'(if_a.so), 32'd21);

        // flush with ce: the shifted word counts
        depth_sel = 4'd0; flush = 1'b1; ce = 1'b1; si = 8'd25;
        step();
        chk("flce_b_so",    32'(if_b.so), 32'd25);
        chk("flce_b_valid", 32'(if_b.so_valid), 32'd1);
        chk("flce_a_so",    32'(if_a.so), 32'd24);
        chk("flce_a_valid", 32'(if_a.so_valid), 32'd1);
        flush = 1'b0; ce = 1'b0; depth_sel = 4'd1;
        #1;
        chk("raise_b_valid", 32'(if_b.so_valid), 32'd0);
        step();
        chk("raise_a_valid", 32'(if_a.so_valid), 32'd0);
        depth_sel = 4'd0;
        #1;
        chk("lower_b_valid", 32'(if_b.so_valid), 32'd1);
        chk("lower_b_so",    32'(if_b.so), 32'd25);
        step();
        chk("lower_a_valid", 32'(if_a.so_valid), 32'd1);
        chk("lower_a_so",    32'(if_a.so), 32'd25);

        // flush without ce: invalid until the next enabled shift
        flush = 1'b1;
        step();
        chk("fl_b_valid",  32'(if_b.so_valid), 32'd0);
        chk("fl_a_valid",  32'(if_a.so_valid), 32'd1);
        flush = 1'b0;
        step();
        chk("fl2_a_valid", 32'(if_a.so_valid), 32'd0);
        chk("fl2_b_valid", 32'(if_b.so_valid), 32'd0);
        ce = 1'b1; si = 8'd26;
        step();
        chk("fl3_b_valid", 32'(if_b.so_valid), 32'd1);
        chk("fl3_b_so",    32'(if_b.so), 32'd26);
        chk("fl3_a_valid", 32'(if_a.so_valid), 32'd0);
        ce = 1'b0;
        step();
        chk("fl4_a_valid", 32'(if_a.so_valid), 32'd1);
        chk("fl4_a_so",    32'(if_a.so), 32'd26);

        // async reset mid-stream
        depth_sel = 4'd3;
        for (int n = 27; n <= 32; n++) begin
            ce = 1'b1; si = 8'(n);
            step();
        end
        chk("pre_rst_b_so", 32'(if_b.so), 32'd29);
        chk("pre_rst_a_so", 32'(if_a.so), 32'd28);
        ce = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_a_so",    32'(if_a.so), 32'd0);
        chk("arst_a_valid", 32'(if_a.so_valid), 32'd0);
        chk("arst_b_valid", 32'(if_b.so_valid), 32'd0);
        chk("arst_c_valid", 32'(if_c.so_valid), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            ce = 1'b1; si = 8'(32 + k);
            step();
            chk("rel_a_valid", 32'(if_a.so_valid), 32'(k >= 5));
            chk("rel_b_valid", 32'(if_b.so_valid), 32'(k >= 4));
            if (k == 5) chk("rel_a_so", 32'(if_a.so), 32'd33);
            if (k == 4) chk("rel_b_so", 32'(if_b.so), 32'd33);
        end

        // depth_sel=15: clamped to 11 on the 12-deep instance
        ce = 1'b0; rst_n = 1'b0; depth_sel = 4'd15;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            ce = 1'b1; si = 8'(40 + k);
            step();
            chk("d15_c_valid", 32'(if_c.so_valid), 32'(k >= 13));
            chk("d15_b_valid", 32'(if_b.so_valid), 32'(k >= 16));
            chk("d15_a_valid", 32'(if_a.so_valid), 32'(k >= 17));
            if (k >= 13) chk("d15_c_so", 32'(if_c.so), 32'(40 + k - 12));
            if (k >= 16) chk("d15_b_so", 32'(if_b.so), 32'(40 + k - 15));
            if (k >= 17) chk("d15_a_so", 32'(if_a.so), 32'(40 + k - 16));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
